// File: rtl/route_collector_pkg.sv
// Shared constants and FSM encoding for the route collector.
package route_collector_pkg;

  localparam int unsigned CHANNEL_NUM   = 128;
  localparam int unsigned CAPACITOR_NUM = 70;
  localparam int unsigned STEP          = 8;
  localparam logic        FILL          = 1'b1;

  localparam int unsigned PTR_W    = $clog2(CAPACITOR_NUM + 1);
  localparam int unsigned STEPS    = CHANNEL_NUM / STEP;
  localparam int unsigned CNT_W    = $clog2(STEPS);
  localparam int unsigned CH_IDX_W = $clog2(CHANNEL_NUM);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_EXPAND = 2'd1;
  localparam logic [1:0] S_HOLD   = 2'd2;

endpackage

// File: rtl/route_collector_slice.sv
// Expands one STEP-wide group of channels from the compacted slot vector.
module route_collector_slice
  import route_collector_pkg::*;
(
  input  logic [STEP-1:0]          mask,
  input  logic [CAPACITOR_NUM-1:0] slots,
  input  logic [PTR_W-1:0]         ptr,
  output logic [STEP-1:0]          ch_c,
  output logic [PTR_W-1:0]         ptr_nxt_c,
  output logic                     ovf_hit_c
);

  logic [PTR_W-1:0] p;

  // Pointer saturates at CAPACITOR_NUM; further enabled channels get FILL.
  always_comb begin
    p         = ptr;
    ch_c      = {STEP{FILL}};
    ovf_hit_c = 1'b0;
    for (int i = 0; i < int'(STEP); i++) begin
      if (mask[i]) begin
        if (p < PTR_W'(CAPACITOR_NUM)) begin
          ch_c[i] = slots[p];
          p       = p + PTR_W'(1);
        end else begin
          ovf_hit_c = 1'b1;
        end
      end
    end
    ptr_nxt_c = p;
  end

endmodule

// File: rtl/route_collector.sv
// Route collector: re-expands compacted capacitor slots onto channel positions.
// Optional unused-slot check enabled by ROUTE_COLLECTOR_UNUSED_CHECK_EN.
module route_collector
  import route_collector_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [CAPACITOR_NUM-1:0] cap_data,
  input  logic [CHANNEL_NUM-1:0]   ch_mask,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CHANNEL_NUM-1:0]   ch_data,
  output logic                     ovf,
  output logic                     err
);

  logic [1:0]               state_q;
  logic [1:0]               state_nxt;
  logic [CAPACITOR_NUM-1:0] cap_q;
  logic [CHANNEL_NUM-1:0]   mask_q;
  logic [PTR_W-1:0]         ptr_q;
  logic [CNT_W-1:0]         cnt_q;

  logic [CH_IDX_W-1:0]      base_c;
  logic [STEP-1:0]          slice_ch_c;
  logic [PTR_W-1:0]         ptr_nxt_c;
  logic                     ovf_hit_c;
  logic                     last_step_c;
  logic                     accept_c;

  assign base_c      = CH_IDX_W'(cnt_q) * CH_IDX_W'(STEP);
  assign last_step_c = (cnt_q == CNT_W'(STEPS - 1));
  assign accept_c    = (state_q == S_IDLE) && in_valid && in_ready;

  route_collector_slice u_slice (
    .mask      (mask_q[base_c +: STEP]),
    .slots     (cap_q),
    .ptr       (ptr_q),
    .ch_c      (slice_ch_c),
    .ptr_nxt_c (ptr_nxt_c),
    .ovf_hit_c (ovf_hit_c)
  );

  // Next-state logic
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      S_IDLE:   if (accept_c) state_nxt = S_EXPAND;
      S_EXPAND: if (last_step_c) state_nxt = S_HOLD;
      S_HOLD:   if (out_ready) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Handshake flags are registered from the next state so they track it exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      cap_q     <= '0;
      mask_q    <= '0;
      ptr_q     <= '0;
      cnt_q     <= '0;
      ch_data   <= {CHANNEL_NUM{FILL}};
      ovf       <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      in_ready  <= (state_nxt == S_IDLE);
      out_valid <= (state_nxt == S_HOLD);
      if (accept_c) begin
        cap_q  <= cap_data;
        mask_q <= ch_mask;
        ptr_q  <= '0;
        cnt_q  <= '0;
        ovf    <= 1'b0;
      end
      if (state_q == S_EXPAND) begin
        ch_data[base_c +: STEP] <= slice_ch_c;
        ptr_q                   <= ptr_nxt_c;
        cnt_q                   <= cnt_q + CNT_W'(1);
        if (ovf_hit_c) ovf <= 1'b1;
      end
    end
  end

`ifdef ROUTE_COLLECTOR_UNUSED_CHECK_EN
  logic unused_bad_c;

  // Slots beyond the final pointer were never consumed and must hold FILL.
  always_comb begin
    unused_bad_c = 1'b0;
    for (int j = 0; j < int'(CAPACITOR_NUM); j++) begin
      if ((PTR_W'(j) >= ptr_nxt_c) && (cap_q[j] != FILL)) unused_bad_c = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (accept_c) begin
      err <= 1'b0;
    end else if ((state_q == S_EXPAND) && last_step_c && unused_bad_c) begin
      err <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_route_collector.sv
// Directed self-checking bench for route_collector.
module tb_route_collector;
  import route_collector_pkg::*;

`ifdef ROUTE_COLLECTOR_UNUSED_CHECK_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif
  localparam int LAT = 17;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     in_valid;
  logic                     in_ready;
  logic [CAPACITOR_NUM-1:0] cap_data;
  logic [CHANNEL_NUM-1:0]   ch_mask;
  logic                     out_valid;
  logic                     out_ready;
  logic [CHANNEL_NUM-1:0]   ch_data;
  logic                     ovf;
  logic                     err;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  route_collector dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .cap_data  (cap_data),
    .ch_mask   (ch_mask),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ch_data   (ch_data),
    .ovf       (ovf),
    .err       (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Presents a frame and returns just after the accepting edge; t_acc is the accept cycle.
  task automatic send(input logic [CHANNEL_NUM-1:0] m, input logic [CAPACITOR_NUM-1:0] c,
                      output int t_acc);
    @(negedge clk);
    ch_mask  = m;
    cap_data = c;
    in_valid = 1'b1;
    t_acc    = cyc;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input int t_acc);
    for (int n = 0; n < 40; n++) begin
      if (out_valid) break;
      @(posedge clk);
      #1;
    end
    chk(tag, 128'(cyc - t_acc), 128'(LAT));
  endtask

  task automatic check_frame(input string tag, input logic [CHANNEL_NUM-1:0] exp_ch,
                             input logic exp_ovf, input logic exp_err);
    chk({tag, "_ch"}, 128'(ch_data), 128'(exp_ch));
    chk({tag, "_ovf"}, 128'(ovf), 128'(exp_ovf));
    chk({tag, "_err"}, 128'(err), 128'(exp_err));
  endtask

  task automatic release_frame(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, "_rel_ov"}, 128'(out_valid), 128'(0));
    chk({tag, "_rel_ir"}, 128'(in_ready), 128'(1));
  endtask

  logic [CHANNEL_NUM-1:0]   m1, m2, m3, mall, m10, e1, e2, e3, ones;
  logic [CAPACITOR_NUM-1:0] c1, c2, c3, c10;
  int ta, ta2, seen;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    cap_data = '0; ch_mask = '0;
    ones = '1;

    m1 = 128'h1;  c1 = '1; c1[0] = 1'b0;
    e1 = '1; e1[0] = 1'b0;
    m2 = '0; m2[3] = 1'b1; m2[10] = 1'b1; m2[127] = 1'b1;
    c2 = '1; c2[1] = 1'b0; c2[2] = 1'b0;
    e2 = '1; e2[10] = 1'b0; e2[127] = 1'b0;
    m3 = '0; m3[69:0] = '1;
    c3 = {35{2'b10}};
    e3 = {{58{1'b1}}, c3};
    mall = '1;
    m10 = '0; m10[9:0] = '1;
    c10 = '1; c10[20] = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ir", 128'(in_ready), 128'(1));
    chk("rst_ov", 128'(out_valid), 128'(0));
    chk("rst_ch", 128'(ch_data), 128'(ones));
    chk("rst_ovf", 128'(ovf), 128'(0));
    chk("rst_err", 128'(err), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Idle with in_valid low must not move
    repeat (3) @(posedge clk);
    #1;
    chk("idle_ir", 128'(in_ready), 128'(1));
    chk("idle_ov", 128'(out_valid), 128'(0));

    send(m1, c1, ta);
    chk("t1_busy", 128'(in_ready), 128'(0));
    wait_valid("t1_lat", ta);
    check_frame("t1", e1, 1'b0, 1'b0);
    release_frame("t1");

    send(m2, c2, ta);
    wait_valid("t2_lat", ta);
    check_frame("t2", e2, 1'b0, 1'b0);
    release_frame("t2");

    send(m3, c3, ta);
    wait_valid("t3_lat", ta);
    check_frame("t3", e3, 1'b0, 1'b0);
    release_frame("t3");

    send(mall, c3, ta);
    wait_valid("t4_lat", ta);
    check_frame("t4", e3, 1'b1, 1'b0);
    release_frame("t4");

    send('0, '1, ta);
    wait_valid("t0_lat", ta);
    check_frame("t0", ones, 1'b0, 1'b0);
    release_frame("t0");

    // Back-pressure: hold frame 3 while a second frame waits on in_valid
    send(m3, c3, ta);
    wait_valid("bp_lat", ta);
    @(negedge clk);
    ch_mask = m1; cap_data = c1; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("bp_ov", 128'(out_valid), 128'(1));
      chk("bp_ir", 128'(in_ready), 128'(0));
      chk("bp_ch", 128'(ch_data), 128'(e3));
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("bp_rel_ov", 128'(out_valid), 128'(0));
    chk("bp_rel_ir", 128'(in_ready), 128'(1));
    ta2 = cyc;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("bp_acc_ir", 128'(in_ready), 128'(0));
    wait_valid("bp2_lat", ta2);
    check_frame("bp2", e1, 1'b0, 1'b0);
    release_frame("bp2");

    // Reset during EXPAND step 4 discards the frame
    send(mall, c3, ta);
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_ov", 128'(out_valid), 128'(0));
    chk("mr_ir", 128'(in_ready), 128'(1));
    chk("mr_ch", 128'(ch_data), 128'(ones));
    chk("mr_ovf", 128'(ovf), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    chk("mr_no_ov", 128'(seen), 128'(0));
    chk("mr_ir_after", 128'(in_ready), 128'(1));
    send(m2, c2, ta);
    wait_valid("mr2_lat", ta);
    check_frame("mr2", e2, 1'b0, 1'b0);
    release_frame("mr2");

    // Unused-slot check: slot 20 beyond final pointer 10 is not FILL
    send(m10, c10, ta);
    wait_valid("uc_lat", ta);
    check_frame("uc", ones, 1'b0, ERR_EN);
    release_frame("uc");

    // err clears on the next accept
    send(m1, c1, ta);
    wait_valid("uc2_lat", ta);
    check_frame("uc2", e1, 1'b0, 1'b0);
    release_frame("uc2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
